// File: rtl/bcd_counter4.sv
// Four-digit packed-BCD up/down counter advanced by a programmable prescaler.
// Supports synchronous clear, validated load, and wrap or saturate at the range ends.
module bcd_counter4 #(
    parameter int unsigned DIV = 50000000,
    parameter bit          SAT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        step,
    output logic        wrap,
    output logic        load_err
);

    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [15:0]   count_nxt;
    logic          range_end;
    logic          load_ok;
    logic          carry;
    logic [3:0]    digit;

    // Ripple carry/borrow across all four digits; carry out of the top digit marks a range end
    always_comb begin
        count_nxt = count;
        carry     = 1'b1;
        load_ok   = 1'b1;
        digit     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    carry              = (digit == 4'd9);
                    count_nxt[4*i +: 4] = carry ? 4'd0 : digit + 4'd1;
                end else begin
                    carry              = (digit == 4'd0);
                    count_nxt[4*i +: 4] = carry ? 4'd9 : digit - 4'd1;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
        range_end = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            presc    <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            step     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                count <= '0;
                presc <= '0;
            end else if (load) begin
                if (load_ok) begin
                    count <= load_val;
                    presc <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (presc == PMAX) begin
                    presc <= '0;
                    if (range_end && SAT) begin
                        wrap <= 1'b1;
                    end else begin
                        count <= count_nxt;
                        step  <= 1'b1;
                        wrap  <= range_end;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed scoreboard bench for bcd_counter4: three instances (DIV=4 wrap, DIV=1 wrap,
// DIV=1 saturate) share stimulus; expectations are queued and checked by a monitor.
module tb_bcd_counter4;

    logic        clk = 1'b0;
    logic        rst, en, up, clr, load;
    logic [15:0] load_val;

    logic [15:0] cnt4, cnt1, cnts;
    logic        stp4, stp1, stps;
    logic        wrp4, wrp1, wrps;
    logic        err4, err1, errs;

    bcd_counter4 #(.DIV(4), .SAT(1'b0)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt4), .step(stp4), .wrap(wrp4), .load_err(err4));

    bcd_counter4 #(.DIV(1), .SAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt1), .step(stp1), .wrap(wrp1), .load_err(err1));

    bcd_counter4 #(.DIV(1), .SAT(1'b1)) dut1s (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(cnts), .step(stps), .wrap(wrps), .load_err(errs));

    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        int          dut;
        logic [15:0] cnt;
        logic        s;
        logic        w;
        logic        e;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t        it;
        logic [15:0] ac;
        logic        as, aw, ae;
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            it = q.pop_front();
            n_chk++;
            case (it.dut)
                4:       begin ac = cnt4; as = stp4; aw = wrp4; ae = err4; end
                1:       begin ac = cnt1; as = stp1; aw = wrp1; ae = err1; end
                default: begin ac = cnts; as = stps; aw = wrps; ae = errs; end
            endcase
            if (it.tgt < cyc) begin
                n_fail++;
                $display("FAIL %s dut%0d: expectation for cycle %0d not sampled (now %0d)",
                         it.tag, it.dut, it.tgt, cyc);
            end else if (ac !== it.cnt || as !== it.s || aw !== it.w || ae !== it.e) begin
                n_fail++;
                $display("FAIL %s dut%0d: got count=%h step=%b wrap=%b load_err=%b, want count=%h step=%b wrap=%b load_err=%b",
                         it.tag, it.dut, ac, as, aw, ae, it.cnt, it.s, it.w, it.e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // dut id: 4 = DIV4/wrap, 1 = DIV1/wrap, 0 = DIV1/saturate
    task automatic expect_out(input int dut, input logic [15:0] c, input logic s,
                              input logic w, input logic e, input string tag);
        exp_t it;
        it.tgt = cyc; it.dut = dut; it.cnt = c; it.s = s; it.w = w; it.e = e; it.tag = tag;
        q.push_back(it);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;

        tick();
        expect_out(4, 16'h0000, 0, 0, 0, "reset");
        expect_out(1, 16'h0000, 0, 0, 0, "reset");
        expect_out(0, 16'h0000, 0, 0, 0, "reset");
        rst = 1'b0; en = 1'b1;

        // Free-running up count from reset
        for (int i = 1; i <= 8; i++) begin
            tick();
            expect_out(4, (i >= 8) ? 16'h0002 : (i >= 4) ? 16'h0001 : 16'h0000,
                       (i % 4) == 0, 0, 0, "div4_up");
            expect_out(1, 16'(i), 1, 0, 0, "div1_up");
            expect_out(0, 16'(i), 1, 0, 0, "sat_up");
        end

        // Load 9998 and step through the top of range
        load = 1'b1; load_val = 16'h9998;
        tick();
        expect_out(1, 16'h9998, 0, 0, 0, "load9998");
        expect_out(0, 16'h9998, 0, 0, 0, "load9998");
        expect_out(4, 16'h9998, 0, 0, 0, "load9998");
        load = 1'b0;
        tick();
        expect_out(1, 16'h9999, 1, 0, 0, "to9999");
        expect_out(0, 16'h9999, 1, 0, 0, "to9999");
        expect_out(4, 16'h9998, 0, 0, 0, "presc_hold");
        tick();
        expect_out(1, 16'h0000, 1, 1, 0, "wrap_up");
        expect_out(0, 16'h9999, 0, 1, 0, "sat_hi");
        expect_out(4, 16'h9998, 0, 0, 0, "presc_hold");
        tick();
        expect_out(1, 16'h0001, 1, 0, 0, "after_wrap");
        expect_out(0, 16'h9999, 0, 1, 0, "sat_hi2");
        expect_out(4, 16'h9998, 0, 0, 0, "presc_hold");

        // Down counting with multi-digit borrow and bottom-of-range wrap
        up = 1'b0; load = 1'b1; load_val = 16'h1000;
        tick();
        expect_out(1, 16'h1000, 0, 0, 0, "load1000");
        load = 1'b0;
        tick();
        expect_out(1, 16'h0999, 1, 0, 0, "borrow");
        tick();
        expect_out(1, 16'h0998, 1, 0, 0, "down");
        load = 1'b1; load_val = 16'h0000;
        tick();
        expect_out(1, 16'h0000, 0, 0, 0, "load0000");
        expect_out(0, 16'h0000, 0, 0, 0, "load0000");
        load = 1'b0;
        tick();
        expect_out(1, 16'h9999, 1, 1, 0, "wrap_down");
        expect_out(0, 16'h0000, 0, 1, 0, "sat_lo");

        // Invalid load is rejected; clear beats load
        load = 1'b1; load_val = 16'h12A4;
        tick();
        expect_out(1, 16'h9999, 0, 0, 1, "bad_load");
        expect_out(0, 16'h0000, 0, 0, 1, "bad_load");
        load = 1'b0; en = 1'b0;
        tick();
        expect_out(1, 16'h9999, 0, 0, 0, "err_one_cycle");
        expect_out(0, 16'h0000, 0, 0, 0, "err_one_cycle");
        clr = 1'b1; load = 1'b1; load_val = 16'h5555; en = 1'b1;
        tick();
        expect_out(4, 16'h0000, 0, 0, 0, "clr_over_load");
        expect_out(1, 16'h0000, 0, 0, 0, "clr_over_load");
        expect_out(0, 16'h0000, 0, 0, 0, "clr_over_load");
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // Async reset mid-prescale: load 0457, advance presc to 2, pulse rst between edges
        up = 1'b1; load = 1'b1; load_val = 16'h0457;
        tick();
        expect_out(4, 16'h0457, 0, 0, 0, "load0457");
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        expect_out(4, 16'h0457, 0, 0, 0, "presc2");
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_out(4, (i == 4) ? 16'h0001 : 16'h0000, i == 4, 0, 0, "post_rst");
            expect_out(1, 16'(i), 1, 0, 0, "post_rst_div1");
        end

        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t it;
            it = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s dut%0d: expectation left unchecked", it.tag, it.dut);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter4.md
BCD_COUNTER4 -- requirements
Module: bcd_counter4

Interface
REQ-001 SHALL have parameter DIV, default 50000000: step period in clk cycles; legal range 1..2^26-1.
REQ-002 SHALL have parameter SAT, default 0: 0 = wrap at the ends of range, 1 = saturate at the ends of range.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: prescaler/count enable.
REQ-006 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement; sampled on the step cycle.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, 16 bits: packed BCD value to load; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-010 SHALL have port count, output, 16 bits: packed BCD count, same nibble order; each nibble feeds one 4-bit digit decoder downstream.
REQ-011 SHALL have port step, output, 1 bit: one-cycle pulse in the cycle after count changed due to a step.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse flagging a range-end event.
REQ-013 SHALL have port load_err, output, 1 bit: one-cycle pulse flagging a rejected load.

Function
REQ-014 SHALL hold a prescaler counter presc of ceil(log2(DIV)) bits (min 1).
- en=1: presc increments each cycle.
- presc==DIV-1 with en=1: a step occurs and presc returns to 0.
- en=0: presc holds.
REQ-015 SHALL make DIV=1 produce a step on every cycle with en=1.
REQ-016 SHALL apply per-cycle priority rst > clr > load > step; a lower-priority event in the same cycle is discarded, not deferred.
REQ-017 SHALL on clr set count=0x0000 and presc=0, with no pulses.
REQ-018 SHALL on load check that every load_val nibble is <=9.
- All valid: count=load_val, presc=0.
- Any nibble >9: count and presc unchanged, load_err=1 next cycle.
REQ-019 SHALL on an up step increment the ones digit.
- Digit 9 becomes 0 and carries into the next digit; the carry ripples within the same cycle.
- Only digits with value 0..9 are ever produced.
REQ-020 SHALL on a down step decrement the ones digit.
- Digit 0 becomes 9 and borrows from the next digit; the borrow ripples within the same cycle.
REQ-021 SHALL at the range ends behave as follows.
- SAT=0: up from 9999 yields 0000 and down from 0000 yields 9999; wrap=1 next cycle.
- SAT=1: up at 9999 and down at 0000 leave count unchanged; wrap=1 next cycle (saturation hit), step=0.
REQ-022 SHALL register step, wrap and load_err, each high for exactly one cycle per event and never asserted while rst is high.
REQ-023 SHALL keep count stable between steps; count changes only on clr, valid load, or a step.
REQ-024 SHALL let a direction change between steps take effect at the next step only; the prescaler phase is unaffected.

Reset
REQ-025 SHALL on rst assertion immediately (asynchronously) force count=0x0000, presc=0, step=0, wrap=0, load_err=0.
REQ-026 SHALL resume counting after rst deassertion with the first step DIV en-cycles later.
REQ-027 SHALL discard any partial prescale period when rst asserts mid-operation.

Verification
REQ-028 SHALL be tested with DIV=4, SAT=0, en=1, up=1 from reset: count=0001 after 4 cycles and 0002 after 8; step pulses once per 4 cycles.
REQ-029 SHALL be tested with load 0x9998, up, DIV=1: count sequence 9999, 0000, 0001; wrap=1 only in the cycle after 9999->0000.
REQ-030 SHALL be tested with load 0x1000, DIV=1, up=0: count=0999, then 0998 (multi-digit borrow); load 0x0000 and one down step -> 9999, wrap=1.
REQ-031 SHALL be tested with load_val=0x12A4: load_err=1 for one cycle and count unchanged; clr and load in the same cycle -> count=0000.
REQ-032 SHALL be tested with SAT=1, load 0x9999, up steps: count stays 9999, wrap pulses each step, step stays 0.
REQ-033 SHALL be tested with rst pulsed asynchronously between clock edges while count=0x0457 and presc=2: count=0000 immediately; first step 4 cycles after release.
